vga_tx_ppc: RTL

- VGA/VESA timing generator and pixel serializer, emitting `ppc` pixels per clock.
  - ppc=1: single data rate.
  - ppc=2: feeds the 2:1 DDR output stage.
  - ppc=4: feeds a future 4:1 gearbox.
- Sits between the pixel FIFO and the `ddr_out` stage.
- Pulls pixels through a valid/ready handshake instead of blind fetch strobes.
- Detects underrun, blanks underrun pixels, and reports frame/line markers.

---
 rtl/vga_tx_ppc.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vga_tx_ppc.sv
// VGA/VESA timing generator and serializer, ppc pixels per beat; outputs registered 1 cycle after counter position.
// Never stalls: pulls beats only in active region, blanks missing beats and flags underrun (count via VGA_TX_PPC_UNDERRUN_CNT_EN).
module vga_tx_ppc #(
  parameter int hva = 1024,
  parameter int hfp = 24,
  parameter int hsp = 136,
  parameter int hbp = 160,
  parameter int vva = 768,
  parameter int vfp = 3,
  parameter int vsp = 6,
  parameter int vbp = 29,
  parameter int hpp = 0,
  parameter int vpp = 0,
  parameter int rd  = 5,
  parameter int gd  = 6,
  parameter int bd  = 5,
  parameter int ppc = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ppc*(rd+gd+bd)-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [ppc*rd-1:0]         R,
  output logic [ppc*gd-1:0]         G,
  output logic [ppc*bd-1:0]         B,
  output logic [ppc-1:0]            HSync,
  output logic [ppc-1:0]            VSync,
  output logic [ppc-1:0]            DE,
  output logic                      sof,
  output logic                      sol,
  output logic                      underrun
`ifdef VGA_TX_PPC_UNDERRUN_CNT_EN
  ,
  input  logic                      cnt_clr,
  output logic [15:0]               underrun_cnt
`endif
);
  localparam int W  = rd + gd + bd;
  localparam int HT = (hva + hfp + hsp + hbp) / ppc;
  localparam int VT = vva + vfp + vsp + vbp;
  localparam int HW = (HT > 1) ? $clog2(HT) : 1;
  localparam int VW = (VT > 1) ? $clog2(VT) : 1;

  // One extra bit so region bounds equal to HT/VT still fit.
  localparam logic [HW:0]   H_ACT  = (HW+1)'(hva / ppc);
  localparam logic [HW:0]   HS_BEG = (HW+1)'((hva + hfp) / ppc);
  localparam logic [HW:0]   HS_END = (HW+1)'((hva + hfp + hsp) / ppc);
  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [VW:0]   V_ACT  = (VW+1)'(vva);
  localparam logic [VW:0]   VS_BEG = (VW+1)'(vva + vfp);
  localparam logic [VW:0]   VS_END = (VW+1)'(vva + vfp + vsp);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic          HPOL   = (hpp != 0);
  localparam logic          VPOL   = (vpp != 0);

  logic [HW-1:0]     r_hc;
  logic [VW-1:0]     r_vc;
  logic [ppc*rd-1:0] r_r;
  logic [ppc*gd-1:0] r_g;
  logic [ppc*bd-1:0] r_b;
  logic [ppc-1:0]    r_hs;
  logic [ppc-1:0]    r_vs;
  logic [ppc-1:0]    r_de;
  logic              r_sof;
  logic              r_sol;
  logic              r_urun;

  logic              w_h_act;
  logic              w_v_act;
  logic              w_active;
  logic              w_hs_on;
  logic              w_vs_on;
  logic              w_pix_ok;
  logic [ppc*rd-1:0] w_r;
  logic [ppc*gd-1:0] w_g;
  logic [ppc*bd-1:0] w_b;

  assign w_h_act  = {1'b0, r_hc} < H_ACT;
  assign w_v_act  = {1'b0, r_vc} < V_ACT;
  assign w_active = w_h_act && w_v_act;
  assign w_hs_on  = ({1'b0, r_hc} >= HS_BEG) && ({1'b0, r_hc} < HS_END);
  assign w_vs_on  = ({1'b0, r_vc} >= VS_BEG) && ({1'b0, r_vc} < VS_END);
  assign w_pix_ok = w_active && in_valid;
  assign in_ready = w_active && rst_n;

  // Each input lane is packed {r,g,b}; split into per-colour buses, lane 0 in LSBs.
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    for (int k = 0; k < ppc; k++) begin
      w_r[k*rd +: rd] = in_data[k*W + gd + bd +: rd];
      w_g[k*gd +: gd] = in_data[k*W + bd +: gd];
      w_b[k*bd +: bd] = in_data[k*W +: bd];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hc   <= '0;
      r_vc   <= '0;
      r_r    <= '0;
      r_g    <= '0;
      r_b    <= '0;
      r_hs   <= {ppc{~HPOL}};
      r_vs   <= {ppc{~VPOL}};
      r_de   <= '0;
      r_sof  <= 1'b0;
      r_sol  <= 1'b0;
      r_urun <= 1'b0;
    end else begin
      if (r_hc == H_LAST) begin
        r_hc <= '0;
        r_vc <= (r_vc == V_LAST) ? '0 : r_vc + VW'(1);
      end else begin
        r_hc <= r_hc + HW'(1);
      end
      r_r   <= w_pix_ok ? w_r : '0;
      r_g   <= w_pix_ok ? w_g : '0;
      r_b   <= w_pix_ok ? w_b : '0;
      r_de  <= {ppc{w_active}};
      r_hs  <= {ppc{w_hs_on ? HPOL : ~HPOL}};
      r_vs  <= {ppc{w_vs_on ? VPOL : ~VPOL}};
      r_sof <= (r_hc == '0) && (r_vc == '0);
      r_sol <= (r_hc == '0) && w_v_act;
      if (w_active && !in_valid) r_urun <= 1'b1;
    end
  end

`ifdef VGA_TX_PPC_UNDERRUN_CNT_EN
  logic [15:0] r_ucnt;

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      r_ucnt <= '0;
    end else if (w_active && !in_valid && (r_ucnt != 16'hFFFF)) begin
      r_ucnt <= r_ucnt + 16'd1;
    end
  end

  assign underrun_cnt = r_ucnt;
`endif

  assign R        = r_r;
  assign G        = r_g;
  assign B        = r_b;
  assign HSync    = r_hs;
  assign VSync    = r_vs;
  assign DE       = r_de;
  assign sof      = r_sof;
  assign sol      = r_sol;
  assign underrun = r_urun;

endmodule
